result_fifo_responder: RTL and testbench
========================================

Name: result_fifo_responder

Overview:
- Responder side of the accelerator's `fifo_command` interface. It stores one datapath result per write command, then drains the stored results to an external reader when the controller issues the read command.
- Sits between the datapath output, the controller's `fifo_command`/`DONE`, and the external `MEM_READ` reader.
- Sized for one full frame of 256 convolution results.

Parameters:
- DATA_W, 16, width of one datapath result word
- DEPTH, 256, number of result entries (power of two)
- ADDR_W, 8, log2(DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- fifo_command  in  2  command from the controller: 2'b00 idle, 2'b10 write, 2'b01 read/drain, 2'b11 illegal
- wr_data  in  DATA_W  datapath result, valid in the cycle a write is accepted
- MEM_READ  in  1  reader ready; a word transfers when rd_valid && MEM_READ
- rd_data  out  DATA_W  head-of-FIFO word, meaningful only while rd_valid=1
- rd_valid  out  1  drain in progress and FIFO non-empty
- drain_done  out  1  one-cycle pulse when a drain empties the FIFO
- fill_count  out  ADDR_W+1  number of stored entries
- full  out  1  fill_count == DEPTH
- empty  out  1  fill_count == 0
- err  out  1  sticky error flag: overflow, write during drain, or illegal command

Behaviour:
- Reset (async, reset=0): state=ACCEPT, both pointers=0, fill_count=0, empty=1, full=0, rd_valid=0, drain_done=0, err=0, rd_data=0. Memory contents are don't-care.
- Commands are edge-qualified. The block registers the previous command (prev_cmd); a command acts only in the cycle where fifo_command != prev_cmd. The controller holds codes as levels, so 2'b01 may persist for many cycles and must trigger exactly one drain.
- ACCEPT state:
  - New 2'b10 with full=0: mem[wr_ptr] <= wr_data, wr_ptr+1 (wraps mod DEPTH), fill_count+1.
  - New 2'b10 with full=1: write dropped, err<=1.
  - New 2'b01: go to DRAIN next cycle.
- DRAIN state:
  - rd_valid = !empty, combinational from state and count.
  - rd_data = mem[rd_ptr], combinational read of the register array.
  - On rd_valid && MEM_READ: rd_ptr+1 (wraps), fill_count-1.
  - When the transfer empties the FIFO, drain_done=1 on the following cycle and state returns to ACCEPT.
  - Drain entered with FIFO already empty: drain_done pulses on the first DRAIN cycle, then ACCEPT.
  - New 2'b10 while in DRAIN: ignored, err<=1.
  - MEM_READ low stalls the drain indefinitely; rd_data and rd_valid stay stable.
- New 2'b11 in any state: no action, err<=1.
- Transition back to 2'b00 is a no-op.
- Write and read can never coincide because the states are exclusive. The pointers therefore never race, and fill_count never changes by two in one cycle.
- Latency:
  - Written word is visible at rd_data no earlier than one cycle after the write edge.
  - First rd_valid occurs one cycle after the 2'b01 edge.
  - Throughput in DRAIN is one word per cycle.
- err clears only on reset.
- Reset mid-drain aborts immediately: FIFO empty, no drain_done pulse.
- Widths:
  - Pointers are ADDR_W bits and wrap naturally.
  - fill_count is ADDR_W+1 bits so DEPTH is representable.
  - full/empty are derived only from fill_count, never from pointer comparison.

Decomposition:
- Shared package, used by both the controller and this block:
  - command code constants CMD_IDLE=2'b00, CMD_WRITE=2'b10, CMD_READ=2'b01, CMD_ILLEGAL=2'b11
  - state constants ACCEPT, DRAIN
- One natural sub-module: result_fifo_mem. It is the DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port, and holds no control logic.
- Edge detection, pointers, count, FSM and flags stay in the top level.

Test Plan:
- Reset, then 3 one-cycle 2'b10 pulses with wr_data 0x0011, 0x0022, 0x0033 -> fill_count=3, empty=0, err=0, rd_valid=0.
- Hold 2'b01 for 20 cycles, MEM_READ=1 -> rd_data 0x0011, 0x0022, 0x0033 on 3 consecutive cycles starting 1 cycle after the edge; one drain_done pulse; empty=1; no second drain despite the held level.
- 256 writes then a 257th -> full=1, fill_count=256, err=1, 257th word absent. Drain with MEM_READ toggling 1/0 -> exactly 256 words in order, stalls hold rd_data.
- 2'b01 with FIFO empty -> drain_done pulse on the first DRAIN cycle, rd_valid never 1, state returns to ACCEPT.
- 2'b10 edge during DRAIN, and a 2'b11 edge -> err=1, fill_count unchanged, drain order unaffected.
- Assert reset=0 asynchronously mid-drain with 5 words left -> outputs reach reset values without a clock edge, no drain_done pulse.

Source files
------------

// File: rtl/result_fifo_responder_pkg.sv
// Shared definitions for the fifo_command interface: command codes and
// responder states, used by both the controller and the result FIFO.
package result_fifo_responder_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'b00,
    CMD_WRITE   = 2'b10,
    CMD_READ    = 2'b01,
    CMD_ILLEGAL = 2'b11
  } cmd_e;

  typedef enum logic {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } state_e;

  // A command acts only in the cycle it differs from the previous one.
  function automatic logic cmd_edge(input cmd_e cur, input cmd_e prev);
    return cur != prev;
  endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Holds no control logic; contents are not reset.
module result_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store one word per accepted write.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_fifo_responder.sv
// Responder for the controller's fifo_command interface: collects one
// datapath result per write edge and drains them to the MEM_READ reader
// when a read edge arrives.
module result_fifo_responder
  import result_fifo_responder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        fifo_command,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              MEM_READ,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              drain_done,
  output logic [ADDR_W:0]   fill_count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  state_e            state_q, state_d;
  cmd_e              prev_cmd_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              drain_done_q, drain_done_d;
  logic              err_q, err_d;

  cmd_e              cmd;
  logic              cmd_new;
  logic              wr_en;
  logic              is_full;
  logic              is_empty;
  logic [DATA_W-1:0] mem_rdata;

  assign cmd      = cmd_e'(fifo_command);
  assign cmd_new  = cmd_edge(cmd, prev_cmd_q);
  assign is_full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign is_empty = (count_q == '0);
  assign wr_en    = (state_q == ACCEPT) && cmd_new && (cmd == CMD_WRITE) && !is_full;

  result_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state logic for the FSM, pointers, count and flags.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drain_done_d = 1'b0;
    err_d        = err_q;

    if (cmd_new && (cmd == CMD_ILLEGAL)) err_d = 1'b1;

    unique case (state_q)
      ACCEPT: begin
        if (cmd_new && (cmd == CMD_WRITE)) begin
          if (is_full) begin
            err_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + (ADDR_W+1)'(1);
          end
        end else if (cmd_new && (cmd == CMD_READ)) begin
          state_d = DRAIN;
          // Empty drain: the pulse lands on the first DRAIN cycle.
          if (is_empty) drain_done_d = 1'b1;
        end
      end
      DRAIN: begin
        if (cmd_new && (cmd == CMD_WRITE)) err_d = 1'b1;
        if (is_empty) begin
          state_d = ACCEPT;
        end else if (MEM_READ) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          count_d  = count_q - (ADDR_W+1)'(1);
          if (count_q == (ADDR_W+1)'(1)) begin
            drain_done_d = 1'b1;
            state_d      = ACCEPT;
          end
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // State, pointer, count and flag registers with async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ACCEPT;
      prev_cmd_q   <= CMD_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_cmd_q   <= cmd;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drain_done_q <= drain_done_d;
      err_q        <= err_d;
    end
  end

  assign rd_valid   = (state_q == DRAIN) && !is_empty;
  assign rd_data    = rd_valid ? mem_rdata : '0;
  assign drain_done = drain_done_q;
  assign fill_count = count_q;
  assign full       = is_full;
  assign empty      = is_empty;
  assign err        = err_q;

endmodule

// File: tb/tb_result_fifo_responder.sv
// Scoreboard bench for result_fifo_responder: writes push expected words,
// a negedge monitor pops and compares every transfer.
module tb_result_fifo_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  fifo_command;
  logic [15:0] wr_data;
  logic        MEM_READ;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        drain_done;
  logic [8:0]  fill_count;
  logic        full;
  logic        empty;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int dd_count = 0;
  int xfers = 0;
  logic [15:0] exp_q [$];

  result_fifo_responder #(
    .DATA_W (16),
    .DEPTH  (256),
    .ADDR_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_command (fifo_command),
    .wr_data      (wr_data),
    .MEM_READ     (MEM_READ),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .drain_done   (drain_done),
    .fill_count   (fill_count),
    .full         (full),
    .empty        (empty),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented word against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (drain_done) dd_count++;
      if (rd_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", rd_data, $time);
        end else if (rd_data != exp_q[0]) begin
          n_bad++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", rd_data, exp_q[0], $time);
          if (MEM_READ) void'(exp_q.pop_front());
        end else if (MEM_READ) begin
          void'(exp_q.pop_front());
        end
        if (MEM_READ) xfers++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    fifo_command = 2'b00;
    MEM_READ = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wr(input logic [15:0] d);
    fifo_command = 2'b10;
    wr_data = d;
    if (exp_q.size() < 256) exp_q.push_back(d);
    @(posedge clk); #1;
    fifo_command = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [1:0] c);
    fifo_command = c;
    @(posedge clk); #1;
    fifo_command = 2'b00;
    @(posedge clk); #1;
  endtask

  // Hold the read command until a drain_done is seen or the budget expires.
  task automatic drain_run(input bit toggle, input int budget);
    int dd0;
    int n;
    dd0 = dd_count;
    n = 0;
    fifo_command = 2'b01;
    MEM_READ = 1'b1;
    while (dd_count == dd0 && n < budget) begin
      @(posedge clk); #1;
      if (toggle) MEM_READ = ~MEM_READ;
      n++;
    end
    check("drain_timeout", int'(dd_count == dd0), 0);
    fifo_command = 2'b00;
    MEM_READ = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int x0;
    int dd0;
    int n;
    reset = 1'b0;
    fifo_command = 2'b00;
    wr_data = '0;
    MEM_READ = 1'b0;
    #3;
    check("rst_fill", fill_count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_err", err, 0);
    check("rst_rd_data", rd_data, 0);
    do_reset();

    // Three writes then a held read level.
    wr(16'h0011); wr(16'h0022); wr(16'h0033);
    check("w3_fill", fill_count, 3);
    check("w3_empty", empty, 0);
    check("w3_err", err, 0);
    check("w3_rd_valid", rd_valid, 0);
    dd0 = dd_count;
    fifo_command = 2'b01;
    MEM_READ = 1'b1;
    check("pre_edge_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    check("first_rd_valid", rd_valid, 1);
    check("first_rd_data", rd_data, 16'h0011);
    repeat (3) @(posedge clk); #1;
    check("drain3_fill", fill_count, 0);
    check("drain3_done", drain_done, 1);
    @(posedge clk); #1;
    check("done_one_cycle", drain_done, 0);
    repeat (15) @(posedge clk); #1;
    check("held_level_one_drain", dd_count - dd0, 1);
    check("held_empty", empty, 1);
    fifo_command = 2'b00;
    MEM_READ = 1'b0;
    @(posedge clk); #1;

    // Fill to capacity, overflow once, drain with stalls.
    for (int i = 0; i < 256; i++) wr(16'(16'h1000 + i * 3));
    check("fill256_full", full, 1);
    check("fill256_count", fill_count, 256);
    check("fill256_err", err, 0);
    wr(16'hDEAD);
    check("ovf_err", err, 1);
    check("ovf_count", fill_count, 256);
    x0 = xfers;
    drain_run(1'b1, 2000);
    check("full_drain_words", xfers - x0, 256);
    check("full_drain_sb_left", exp_q.size(), 0);
    check("full_drain_empty", empty, 1);

    // Read edge with nothing stored.
    do_reset();
    fifo_command = 2'b01;
    @(posedge clk); #1;
    check("empty_drain_done", drain_done, 1);
    check("empty_drain_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    check("empty_drain_done_end", drain_done, 0);
    check("empty_drain_rd_valid2", rd_valid, 0);
    fifo_command = 2'b00;
    @(posedge clk); #1;
    check("empty_drain_err", err, 0);
    wr(16'h0777);
    check("back_in_accept", fill_count, 1);

    // Write edge during a drain.
    do_reset();
    wr(16'h00B1); wr(16'h00B2); wr(16'h00B3); wr(16'h00B4);
    fifo_command = 2'b01;
    MEM_READ = 1'b0;
    @(posedge clk); #1;
    check("stall_rd_valid", rd_valid, 1);
    fifo_command = 2'b10;
    wr_data = 16'hEEEE;
    @(posedge clk); #1;
    check("wr_in_drain_err", err, 1);
    check("wr_in_drain_fill", fill_count, 4);
    drain_run(1'b0, 50);
    check("wr_in_drain_sb_left", exp_q.size(), 0);

    // Illegal command edge.
    do_reset();
    wr(16'h00C1); wr(16'h00C2);
    pulse(2'b11);
    check("illegal_err", err, 1);
    check("illegal_fill", fill_count, 2);
    drain_run(1'b0, 50);
    check("illegal_sb_left", exp_q.size(), 0);

    // Asynchronous reset mid-drain with five words left.
    do_reset();
    for (int i = 0; i < 8; i++) wr(16'(16'h00A0 + i));
    fifo_command = 2'b01;
    MEM_READ = 1'b1;
    n = 0;
    while (fill_count != 5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_drain_reach5", fill_count, 5);
    dd0 = dd_count;
    #2;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("async_fill", fill_count, 0);
    check("async_empty", empty, 1);
    check("async_rd_valid", rd_valid, 0);
    check("async_rd_data", rd_data, 0);
    check("async_drain_done", drain_done, 0);
    fifo_command = 2'b00;
    MEM_READ = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("async_no_done_pulse", dd_count - dd0, 0);
    check("async_after_fill", fill_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
